// File: rtl/bp_pkg.sv
// Shared types for the branch-predictor request sequencer and its in-flight queue.
package bp_pkg;

    localparam int BP_W = 32;

    typedef enum logic [1:0] {
        BP_IDLE      = 2'd0,
        BP_PRED_WAIT = 2'd1,
        BP_RES_WAIT  = 2'd2
    } bp_state_e;

    // Entry fields are sized by BP_W, so the sequencer's W must equal BP_W.
    typedef struct packed {
        logic [BP_W-1:0] pc;
        logic            taken;
        logic [BP_W-1:0] target;
    } bp_entry_t;

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of outstanding predictions. Flush empties the queue and wins over push.
module bp_inflight_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  bp_entry_t              i_entry,
    output bp_entry_t              o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int AW = $clog2(DEPTH);

    bp_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    // NOTE: storage is not reset; pointers and occupancy alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/bp_request_sequencer.sv
// Issues predict/resolve requests to the Gshare predictor and tracks in-flight predictions
// so a wrong one produces a redirect and flushes the younger wrong-path entries.
module bp_request_sequencer
    import bp_pkg::*;
#(
    parameter int W       = BP_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fe_valid,
    output logic                   fe_ready,
    input  logic [W-1:0]           fe_pc,
    output logic                   fe_pred_valid,
    output logic                   fe_pred_taken,
    output logic [W-1:0]           fe_pred_target,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic                   ex_taken,
    input  logic [W-1:0]           ex_target,
    output logic                   mispredict,
    output logic [W-1:0]           redirect_pc,
    output logic                   start_pred,
    output logic                   start_resolve,
    output logic [W-1:0]           PC,
    output logic [W-1:0]           actual_target,
    output logic                   pr_hit,
    input  logic                   BR_PRED,
    input  logic [W-1:0]           TARGET,
    input  logic                   DONE,
    output logic [$clog2(DEPTH):0] inflight,
    output logic                   err_timeout
);

    localparam logic [1:0] S_IDLE      = BP_IDLE;
    localparam logic [1:0] S_PRED_WAIT = BP_PRED_WAIT;
    localparam logic [1:0] S_RES_WAIT  = BP_RES_WAIT;
    localparam int         CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [CW-1:0] r_wait_cnt;
    logic          r_start_pred;
    logic          r_start_resolve;
    logic [W-1:0]  r_pc;
    logic [W-1:0]  r_actual_target;
    logic          r_pr_hit;
    logic          r_ex_taken;
    logic          r_fe_pred_valid;
    logic          r_fe_pred_taken;
    logic [W-1:0]  r_fe_pred_target;
    logic          r_mispredict;
    logic [W-1:0]  r_redirect_pc;
    logic          r_err_timeout;

    logic          w_idle;
    logic          w_wait;
    logic          w_expired;
    logic          w_finish;
    logic          w_pred_accept;
    logic          w_res_accept;
    logic          w_hit;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_flush;
    bp_entry_t     w_head;
    bp_entry_t     w_push_entry;

    assign w_idle    = (r_state == S_IDLE);
    assign w_wait    = !w_idle;
    assign w_expired = w_wait && (r_wait_cnt == TO_LAST);
    assign w_finish  = w_wait && (DONE || w_expired);

    // Readies are gated by reset so every output reads 0 while reset is held.
    assign ex_ready      = rst && w_idle && !w_empty;
    assign fe_ready      = rst && w_idle && !w_full && !ex_valid;
    assign w_res_accept  = ex_valid && ex_ready;
    assign w_pred_accept = fe_valid && fe_ready;

    assign w_hit = (w_head.taken == ex_taken) && (!ex_taken || (w_head.target == ex_target));

    assign w_push       = (r_state == S_PRED_WAIT) && DONE;
    assign w_pop        = (r_state == S_RES_WAIT) && w_finish && r_pr_hit;
    assign w_flush      = (r_state == S_RES_WAIT) && w_finish && !r_pr_hit;
    assign w_push_entry = '{pc: r_pc, taken: BR_PRED, target: TARGET};

    bp_inflight_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_entry (w_push_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (inflight)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= S_IDLE;
            r_wait_cnt       <= '0;
            r_start_pred     <= 1'b0;
            r_start_resolve  <= 1'b0;
            r_pc             <= '0;
            r_actual_target  <= '0;
            r_pr_hit         <= 1'b0;
            r_ex_taken       <= 1'b0;
            r_fe_pred_valid  <= 1'b0;
            r_fe_pred_taken  <= 1'b0;
            r_fe_pred_target <= '0;
            r_mispredict     <= 1'b0;
            r_redirect_pc    <= '0;
            r_err_timeout    <= 1'b0;
        end else begin
            r_fe_pred_valid <= 1'b0;
            r_mispredict    <= 1'b0;
            if (w_wait && !DONE && w_expired) begin
                r_err_timeout <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_res_accept) begin
                        r_pc            <= w_head.pc;
                        r_actual_target <= ex_target;
                        r_pr_hit        <= w_hit;
                        r_ex_taken      <= ex_taken;
                        r_start_resolve <= 1'b1;
                        r_wait_cnt      <= '0;
                        r_state         <= S_RES_WAIT;
                    end else if (w_pred_accept) begin
                        r_pc         <= fe_pc;
                        r_start_pred <= 1'b1;
                        r_wait_cnt   <= '0;
                        r_state      <= S_PRED_WAIT;
                    end
                end
                S_PRED_WAIT: begin
                    if (DONE) begin
                        r_fe_pred_valid  <= 1'b1;
                        r_fe_pred_taken  <= BR_PRED;
                        r_fe_pred_target <= TARGET;
                    end
                    if (w_finish) begin
                        r_start_pred <= 1'b0;
                        r_wait_cnt   <= '0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_RES_WAIT: begin
                    // A timed-out resolve still retires the head and may redirect.
                    if (w_finish) begin
                        r_start_resolve <= 1'b0;
                        r_wait_cnt      <= '0;
                        r_state         <= S_IDLE;
                        if (!r_pr_hit) begin
                            r_mispredict  <= 1'b1;
                            r_redirect_pc <= r_ex_taken ? r_actual_target : r_pc + W'(4);
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign start_pred     = r_start_pred;
    assign start_resolve  = r_start_resolve;
    assign PC             = r_pc;
    assign actual_target  = r_actual_target;
    assign pr_hit         = r_pr_hit;
    assign fe_pred_valid  = r_fe_pred_valid;
    assign fe_pred_taken  = r_fe_pred_taken;
    assign fe_pred_target = r_fe_pred_target;
    assign mispredict     = r_mispredict;
    assign redirect_pc    = r_redirect_pc;
    assign err_timeout    = r_err_timeout;

endmodule

// File: tb/tb_bp_request_sequencer.sv
// Directed bench for bp_request_sequencer with a hand-driven predictor stub.
module tb_bp_request_sequencer;

    localparam int W       = 32;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         fe_valid = 1'b0;
    logic         fe_ready;
    logic [W-1:0] fe_pc = '0;
    logic         fe_pred_valid;
    logic         fe_pred_taken;
    logic [W-1:0] fe_pred_target;
    logic         ex_valid = 1'b0;
    logic         ex_ready;
    logic         ex_taken = 1'b0;
    logic [W-1:0] ex_target = '0;
    logic         mispredict;
    logic [W-1:0] redirect_pc;
    logic         start_pred;
    logic         start_resolve;
    logic [W-1:0] PC;
    logic [W-1:0] actual_target;
    logic         pr_hit;
    logic         BR_PRED = 1'b0;
    logic [W-1:0] TARGET = '0;
    logic         DONE = 1'b0;
    logic [$clog2(DEPTH):0] inflight;
    logic         err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bp_request_sequencer #(
        .W       (W),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fe_valid       (fe_valid),
        .fe_ready       (fe_ready),
        .fe_pc          (fe_pc),
        .fe_pred_valid  (fe_pred_valid),
        .fe_pred_taken  (fe_pred_taken),
        .fe_pred_target (fe_pred_target),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_taken       (ex_taken),
        .ex_target      (ex_target),
        .mispredict     (mispredict),
        .redirect_pc    (redirect_pc),
        .start_pred     (start_pred),
        .start_resolve  (start_resolve),
        .PC             (PC),
        .actual_target  (actual_target),
        .pr_hit         (pr_hit),
        .BR_PRED        (BR_PRED),
        .TARGET         (TARGET),
        .DONE           (DONE),
        .inflight       (inflight),
        .err_timeout    (err_timeout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Predict request; stub answers after lat cycles of start_pred.
    task automatic do_predict(input logic [W-1:0] pc, input int lat,
                              input logic taken, input logic [W-1:0] tgt);
        int hi = 0;
        check("pred_fe_ready", 64'(fe_ready), 64'(1));
        fe_valid = 1'b1;
        fe_pc    = pc;
        tick();
        fe_valid = 1'b0;
        check("pred_pc", 64'(PC), 64'(pc));
        for (int i = 0; i < lat; i++) begin
            if (start_pred) hi++;
            tick();
        end
        DONE    = 1'b1;
        BR_PRED = taken;
        TARGET  = tgt;
        if (start_pred) hi++;
        tick();
        DONE    = 1'b0;
        BR_PRED = 1'b0;
        TARGET  = '0;
        check("pred_start_cycles", 64'(hi), 64'(lat + 1));
        check("pred_start_low", 64'(start_pred), 64'(0));
        check("fe_pred_valid", 64'(fe_pred_valid), 64'(1));
        check("fe_pred_taken", 64'(fe_pred_taken), 64'(taken));
        check("fe_pred_target", 64'(fe_pred_target), 64'(tgt));
    endtask

    // Resolve the oldest entry; stub answers after lat cycles of start_resolve.
    task automatic do_resolve(input logic tk, input logic [W-1:0] tgt, input int lat,
                              input logic [W-1:0] exp_pc, input logic exp_hit,
                              input logic [W-1:0] exp_redir, input int exp_left);
        int hi = 0;
        check("res_ex_ready", 64'(ex_ready), 64'(1));
        ex_valid  = 1'b1;
        ex_taken  = tk;
        ex_target = tgt;
        tick();
        ex_valid  = 1'b0;
        ex_taken  = 1'b0;
        ex_target = '0;
        check("res_pc", 64'(PC), 64'(exp_pc));
        check("res_actual_target", 64'(actual_target), 64'(tgt));
        check("res_pr_hit", 64'(pr_hit), 64'(exp_hit));
        check("res_no_start_pred", 64'(start_pred), 64'(0));
        for (int i = 0; i < lat; i++) begin
            if (start_resolve) hi++;
            tick();
        end
        DONE = 1'b1;
        if (start_resolve) hi++;
        tick();
        DONE = 1'b0;
        check("res_start_cycles", 64'(hi), 64'(lat + 1));
        check("res_start_low", 64'(start_resolve), 64'(0));
        check("res_mispredict", 64'(mispredict), 64'(!exp_hit));
        if (!exp_hit) check("res_redirect_pc", 64'(redirect_pc), 64'(exp_redir));
        check("res_inflight", 64'(inflight), 64'(exp_left));
    endtask

    initial begin
        int hi;

        // Reset held: every output is 0.
        repeat (2) tick();
        check("rst_ctrl", 64'({fe_ready, ex_ready, fe_pred_valid, fe_pred_taken, mispredict,
                               start_pred, start_resolve, pr_hit, err_timeout, inflight}), 64'(0));
        check("rst_pc", 64'(PC), 64'(0));
        check("rst_redirect", 64'(redirect_pc), 64'(0));
        check("rst_actual_target", 64'(actual_target), 64'(0));
        check("rst_pred_target", 64'(fe_pred_target), 64'(0));
        rst = 1'b1;
        tick();
        check("idle_fe_ready", 64'(fe_ready), 64'(1));
        check("idle_ex_ready", 64'(ex_ready), 64'(0));
        check("idle_inflight", 64'(inflight), 64'(0));

        // Reset in the middle of PRED_WAIT with one entry queued.
        do_predict(32'h0000_0A00, 0, 1'b1, 32'h0000_0B00);
        check("mid_inflight_before", 64'(inflight), 64'(1));
        fe_valid = 1'b1;
        fe_pc    = 32'h0000_0C00;
        tick();
        fe_valid = 1'b0;
        check("mid_start_pred", 64'(start_pred), 64'(1));
        rst = 1'b0;
        tick();
        check("mid_rst_start_pred", 64'(start_pred), 64'(0));
        check("mid_rst_inflight", 64'(inflight), 64'(0));
        check("mid_rst_pc", 64'(PC), 64'(0));
        rst = 1'b1;
        tick();
        check("mid_rst_fe_ready", 64'(fe_ready), 64'(1));

        // First-encounter branch: predicted not-taken, actually taken.
        do_predict(32'h0000_1000, 2, 1'b0, 32'h0);
        check("first_inflight", 64'(inflight), 64'(1));
        do_resolve(1'b1, 32'h1000_0000, 1, 32'h0000_1000, 1'b0, 32'h1000_0000, 0);
        tick();
        check("mispredict_pulse_end", 64'(mispredict), 64'(0));

        // Trained branch, varying stub latency.
        for (int i = 0; i < 7; i++) begin
            do_predict(32'h0000_2000, i % 3, 1'b1, 32'h1000_0000);
            do_resolve(1'b1, 32'h1000_0000, i % 3, 32'h0000_2000, 1'b1, 32'h0, 0);
        end

        // Hits pop one entry at a time; a not-taken hit ignores the target.
        do_predict(32'h0000_3000, 0, 1'b1, 32'h0000_5000);
        do_predict(32'h0000_3100, 0, 1'b0, 32'h0000_1234);
        do_resolve(1'b1, 32'h0000_5000, 0, 32'h0000_3000, 1'b1, 32'h0, 1);
        do_resolve(1'b0, 32'h0000_9999, 0, 32'h0000_3100, 1'b1, 32'h0, 0);

        // Right direction, wrong target.
        do_predict(32'h0000_3200, 0, 1'b1, 32'h0000_5000);
        do_resolve(1'b1, 32'h0000_6000, 0, 32'h0000_3200, 1'b0, 32'h0000_6000, 0);

        // Fall-through address wraps modulo 2^W.
        do_predict(32'hFFFF_FFFC, 0, 1'b1, 32'h0000_0040);
        do_resolve(1'b0, 32'h0, 0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 0);

        // Fill the queue, then mispredict the head and flush.
        for (int i = 0; i < DEPTH; i++) begin
            do_predict(32'((i + 1) * 32'h1000), 1, 1'b1, 32'h0000_5000);
        end
        check("full_fe_ready", 64'(fe_ready), 64'(0));
        check("full_inflight", 64'(inflight), 64'(4));
        fe_valid = 1'b1;
        fe_pc    = 32'h0000_9000;
        repeat (3) tick();
        check("full_no_start", 64'(start_pred), 64'(0));
        check("full_inflight_held", 64'(inflight), 64'(4));
        fe_valid = 1'b0;
        do_resolve(1'b0, 32'h0, 1, 32'h0000_1000, 1'b0, 32'h0000_1004, 0);

        // Simultaneous predict and resolve: resolve goes first.
        do_predict(32'h0000_6000, 0, 1'b1, 32'h0000_6100);
        fe_valid  = 1'b1;
        fe_pc     = 32'h0000_7000;
        ex_valid  = 1'b1;
        ex_taken  = 1'b1;
        ex_target = 32'h0000_6100;
        #1;
        check("both_fe_ready", 64'(fe_ready), 64'(0));
        check("both_ex_ready", 64'(ex_ready), 64'(1));
        tick();
        ex_valid = 1'b0;
        check("both_start_resolve", 64'(start_resolve), 64'(1));
        check("both_start_pred", 64'(start_pred), 64'(0));
        check("both_res_pc", 64'(PC), 64'(32'h0000_6000));
        DONE = 1'b1;
        tick();
        DONE = 1'b0;
        check("both_res_done", 64'(start_resolve), 64'(0));
        check("both_no_mispredict", 64'(mispredict), 64'(0));
        check("both_inflight0", 64'(inflight), 64'(0));
        #1;
        check("both_fe_ready_after", 64'(fe_ready), 64'(1));
        tick();
        fe_valid = 1'b0;
        check("both_start_pred_after", 64'(start_pred), 64'(1));
        check("both_pred_pc", 64'(PC), 64'(32'h0000_7000));
        DONE    = 1'b1;
        BR_PRED = 1'b0;
        TARGET  = 32'h0000_7777;
        tick();
        DONE    = 1'b0;
        TARGET  = '0;
        check("both_pred_valid", 64'(fe_pred_valid), 64'(1));
        check("both_inflight1", 64'(inflight), 64'(1));

        // Predict timeout: DONE never comes.
        fe_valid = 1'b1;
        fe_pc    = 32'h0000_8000;
        tick();
        fe_valid = 1'b0;
        hi = 0;
        while (start_pred && hi < 200) begin
            hi++;
            tick();
        end
        check("to_pred_cycles", 64'(hi), 64'(TIMEOUT));
        check("to_pred_err", 64'(err_timeout), 64'(1));
        check("to_pred_no_valid", 64'(fe_pred_valid), 64'(0));
        check("to_pred_inflight", 64'(inflight), 64'(1));
        check("to_pred_idle", 64'(fe_ready), 64'(1));

        // Resolve timeout: head still retires and the mispredict fires.
        ex_valid  = 1'b1;
        ex_taken  = 1'b1;
        ex_target = 32'h0000_8800;
        tick();
        ex_valid = 1'b0;
        check("to_res_start", 64'(start_resolve), 64'(1));
        check("to_res_hit", 64'(pr_hit), 64'(0));
        hi = 0;
        while (start_resolve && hi < 200) begin
            hi++;
            tick();
        end
        check("to_res_cycles", 64'(hi), 64'(TIMEOUT));
        check("to_res_mispredict", 64'(mispredict), 64'(1));
        check("to_res_redirect", 64'(redirect_pc), 64'(32'h0000_8800));
        check("to_res_inflight", 64'(inflight), 64'(0));
        check("to_res_err", 64'(err_timeout), 64'(1));

        // Only reset clears the sticky error.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("err_cleared", 64'(err_timeout), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bp_request_sequencer.md
# bp_request_sequencer

Initiator side of the branch-predictor request/resolve handshake. Accepts branch PCs from fetch and issues `start_pred` requests to the Gshare predictor. It keeps each prediction in an in-order in-flight queue. When execute resolves a branch, it computes `pr_hit` against the queued prediction, issues `start_resolve`, and raises a mispredict redirect with a queue flush. It sits between the fetch/execute pipeline stages and the Gshare predictor top.

## Interface

Parameters:
- `W`, 32, PC/target width.
- `DEPTH`, 4, in-flight prediction queue entries (power of 2, ≥2).
- `TIMEOUT`, 64, max cycles waiting for `DONE` before error.

Ports, in the order name, direction, width, meaning:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `fe_valid` in 1 / `fe_ready` out 1 / `fe_pc` in W: fetch prediction request (valid/ready).
- `fe_pred_valid` out 1 / `fe_pred_taken` out 1 / `fe_pred_target` out W: prediction returned to fetch (1-cycle pulse).
- `ex_valid` in 1 / `ex_ready` out 1 / `ex_taken` in 1 / `ex_target` in W: execute resolution of the oldest in-flight branch.
- `mispredict` out 1: 1-cycle pulse on wrong prediction.
- `redirect_pc` out W: correct fetch PC, valid with `mispredict`.
- `start_pred` out 1 / `start_resolve` out 1 / `PC` out W / `actual_target` out W / `pr_hit` out 1: predictor request side.
- `BR_PRED` in 1 / `TARGET` in W / `DONE` in 1: predictor response.
- `inflight` out $clog2(DEPTH)+1: queue occupancy.
- `err_timeout` out 1: sticky; set on `DONE` timeout, cleared only by reset.

## Operation

- FSM states: IDLE, PRED_WAIT, RES_WAIT.
- IDLE:
  - `ex_ready` = (queue not empty); `fe_ready` = (queue not full) && !`ex_valid`.
  - Resolve has priority over predict when both are valid.
  - `ex_valid` with an empty queue is ignored (`ex_ready`=0).
- Predict accept (`fe_valid`&&`fe_ready`):
  - latch `PC`=`fe_pc`, assert `start_pred`, go to PRED_WAIT.
- PRED_WAIT:
  - On `DONE`, push {PC, BR_PRED, TARGET} to the queue.
  - Pulse `fe_pred_valid` with `fe_pred_taken`=BR_PRED and `fe_pred_target`=TARGET.
  - Drop `start_pred`, go to IDLE.
- Resolve accept (`ex_valid`&&`ex_ready`):
  - Head entry h. `PC`=h.pc, `actual_target`=`ex_target`.
  - `pr_hit` = (h.taken==`ex_taken`) && (!`ex_taken` || h.target==`ex_target`).
  - Assert `start_resolve`, go to RES_WAIT.
- RES_WAIT:
  - On `DONE`, pop the head and drop `start_resolve`.
  - If !`pr_hit`: pulse `mispredict`; `redirect_pc` = `ex_taken` ? `ex_target` : h.pc+4 (mod 2^W). Flush all remaining entries (younger, wrong-path). Go to IDLE.
- `start_pred`/`start_resolve` are never high together. `PC`, `actual_target` and `pr_hit` are held stable while a start is high.
- `DONE` in IDLE is ignored.
- Timeout:
  - Wait counter counts cycles in a WAIT state.
  - On reaching TIMEOUT: set `err_timeout`, drop the start, go to IDLE.
  - Predict timeout: no push and no `fe_pred_valid`.
  - Resolve timeout: head is still popped and the mispredict logic still applies.
- Reset (any state, incl. mid-handshake): every output is 0, queue empty, FSM in IDLE, counter 0. Outputs are 0 from the first edge with `rst`=0.

## Timing

- Request accepted at edge N: the start is high from cycle N+1 through the cycle where `DONE`=1 (cycle D), inclusive. The start is low from D+1.
- `fe_pred_valid`/`mispredict` are registered: high exactly in cycle D+1. The queue push/pop/flush is visible in D+1.
- Next request is accepted at the earliest at edge D+1 (`*_ready` high in D+1). Minimum turnaround: 2 cycles per request with zero-wait `DONE`.
- `DONE` is sampled only while the matching start is high. A `DONE` that is held high is consumed once.
- Queue full: `fe_ready`=0. Push with the queue full cannot occur, since the acceptance gate prevents it.
- Pointer wrap is modulo DEPTH. `inflight` = DEPTH when full.

## Structure

- Package `bp_pkg`: FSM state enum, `bp_entry_t` struct {pc, taken, target}, default W.
- Sub-module `bp_inflight_fifo`: DEPTH×`bp_entry_t`, push/pop/flush, full/empty/count. Flush takes priority over push in the same cycle.

## Test plan

- Reset then idle: all outputs 0, `fe_ready`=1, `ex_ready`=0. Assert reset mid-PRED_WAIT → `start_pred` is 0 on the next edge and `inflight`=0.
- First-encounter branch: predict PC=0x1000, stub returns BR_PRED=0 after 2 cycles. Resolve taken to 0x10000000. Expected: `pr_hit`=0, `mispredict` pulse, `redirect_pc`=0x10000000.
- Trained branch: stub returns BR_PRED=1, TARGET=0x10000000, repeated 7×. Expected: `pr_hit`=1 every time, no `mispredict`, `start` high cycles = stub latency+1.
- Fill the queue: PCs 0x1000–0x4000 with no resolves. Expected: `fe_ready`=0, `inflight`=4. Then resolve head not-taken while it was predicted taken. Expected: `redirect_pc`=0x1004 and `inflight`=0 after flush.
- Simultaneous `fe_valid`/`ex_valid` in IDLE → resolve is issued first, predict on the following IDLE.
- Stub never asserts `DONE` → `err_timeout`=1 after 64 cycles, start dropped, FSM in IDLE.
